sfi_mem_req: RTL and testbench
==============================

Name: sfi_mem_req

Overview:
- Downstream consumer of the SFI address sandbox stage.
- Takes the original address (ri) and the SFI-filtered address (ro) per request and decides whether the access may proceed.
- Legal accesses become single-beat memory read/write transactions. Illegal accesses never reach memory; they return an immediate fault response and are logged.
- Sits between the SFI checker and the data-memory port.

Parameters:
- AW, 64, address width (matches SFI ri/ro).
- DW, 64, data width.
- CW, 16, fault counter width.
- TIMEOUT, 255, max cycles in WAIT_R before a read is abandoned (1..2^16-1).

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid & in_ready
- in_ri  in  AW  original effective address
- in_ro  in  AW  SFI output address
- in_we  in  1  1=write, 0=read
- in_wdata  in  DW  write data
- mem_req  out  1  memory request
- mem_gnt  in  1  memory grant
- mem_addr  out  AW  memory address (= captured ro)
- mem_we  out  1  memory write enable
- mem_wdata  out  DW  memory write data
- mem_rvalid  in  1  read data valid
- mem_rdata  in  DW  read data
- resp_valid  out  1  response valid
- resp_ready  in  1  response consumed when resp_valid & resp_ready
- resp_data  out  DW  read data (0 for writes/faults/timeouts)
- resp_fault  out  1  sandbox violation
- resp_err  out  1  read timeout
- fault_sticky  out  1  set on any violation
- fault_cnt  out  CW  saturating violation count
- fault_addr  out  AW  ri of most recent violation
- fault_clr  in  1  clears fault_sticky and fault_cnt

Behaviour:
- Reset (rst_n low at edge):
  - state=IDLE.
  - in_ready=1; mem_req, resp_valid, resp_fault, resp_err, fault_sticky = 0.
  - fault_cnt=0, fault_addr=0, resp_data=0, mem_addr/mem_we/mem_wdata=0.
  - Reset mid-transaction abandons it: no response, and mem_req is low from the next cycle.
- Violation: captured ro != captured ri (SFI zeroes bad addresses; ri=0 is legal).
- FSM states IDLE, REQ, WAIT_R, RESP. Registered outputs, one request in flight, no pipelining.
- IDLE:
  - in_ready=1, all other handshake outputs 0.
  - On accept, capture ri/ro/we/wdata.
  - Violation: go to RESP with resp_fault=1, resp_data=0. fault_sticky<=1, fault_addr<=ri, fault_cnt<=fault_cnt+1 (saturates at all-ones).
  - Legal: go to REQ.
- REQ:
  - mem_req=1; mem_addr/mem_we/mem_wdata held stable until mem_gnt.
  - On gnt: mem_req drops next cycle. Write goes to RESP (resp_data=0). Read goes to WAIT_R with timer=0.
- WAIT_R:
  - Timer increments each cycle.
  - mem_rvalid: resp_data<=mem_rdata, go to RESP.
  - Timer reaches TIMEOUT without rvalid: RESP with resp_err=1, resp_data=0.
  - rvalid on the same cycle as timeout: data wins, resp_err=0.
- RESP:
  - resp_valid=1; resp_* held stable until resp_ready.
  - Then go to IDLE with resp_valid/fault/err cleared.
  - in_ready=0 in every state except IDLE.
- Latency:
  - Accept at edge N gives mem_req high from N+1.
  - Fault response: resp_valid high from N+1.
  - Write with immediate gnt: resp_valid from N+2.
- mem_gnt outside REQ and mem_rvalid outside WAIT_R are ignored.
- fault_clr:
  - Zeroes fault_cnt and fault_sticky.
  - If a violation is accepted in the same cycle: fault_cnt<=1, fault_sticky<=1, fault_addr updated.

Test Plan:
- Legal read: ri=ro=0xA2199872, gnt after 1 cycle, rvalid with 0xDEADBEEF 3 cycles later -> mem_addr=0xA2199872, resp_data=0xDEADBEEF, resp_fault=0, resp_err=0.
- Violation: ri=0x00FFEEDD, ro=0 -> mem_req never asserts; resp_valid next cycle with resp_fault=1, resp_data=0; fault_cnt=1, fault_sticky=1, fault_addr=0x00FFEEDD.
- Read timeout, TIMEOUT=4, no rvalid -> resp_err=1, resp_data=0 after 4 WAIT_R cycles. A late rvalid arriving in IDLE is ignored.
- Backpressure: legal write 0x1234 to 0xA2199872, resp_ready low 5 cycles -> resp_valid and resp_* stable, in_ready=0 throughout. Returns to IDLE one cycle after resp_ready.
- Counter: CW=2, four violations -> fault_cnt saturates at 3. Fault_clr on the same cycle as a fifth violation -> fault_cnt=1, fault_sticky=1.
- Reset mid-op: rst_n low during REQ -> next cycle mem_req=0, state IDLE, in_ready=1, all fault state cleared.

Source files
------------

// File: rtl/sfi_mem_req.sv
// sfi_mem_req: turns SFI-checked addresses into single-beat memory accesses.
// Sandbox violations (ro != ri) never reach memory. They return an immediate
// fault response and are logged in the sticky flag, counter and address registers.
module sfi_mem_req #(
  parameter int unsigned AW      = 64,
  parameter int unsigned DW      = 64,
  parameter int unsigned CW      = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] in_ri,
  input  logic [AW-1:0] in_ro,
  input  logic          in_we,
  input  logic [DW-1:0] in_wdata,
  output logic          mem_req,
  input  logic          mem_gnt,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [DW-1:0] resp_data,
  output logic          resp_fault,
  output logic          resp_err,
  output logic          fault_sticky,
  output logic [CW-1:0] fault_cnt,
  output logic [AW-1:0] fault_addr,
  input  logic          fault_clr
);

  localparam int unsigned TW = 16;
  // WAIT_R is left on the cycle the timer holds TIMEOUT-1.
  // The read therefore spends exactly TIMEOUT cycles waiting.
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R, RESP} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   ro_q;
  logic            we_q;
  logic [DW-1:0]   wdata_q;
  logic [TW-1:0]   timer_q;
  logic [DW-1:0]   resp_data_q;
  logic            resp_fault_q;
  logic            resp_err_q;
  logic            sticky_q;
  logic [CW-1:0]   cnt_q;
  logic [AW-1:0]   faddr_q;

  logic            accept;
  logic            violation;
  logic            timed_out;

  assign accept    = (state_q == IDLE) && in_valid;
  assign violation = (in_ro != in_ri);
  assign timed_out = (timer_q == TLAST);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state selection
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid)                   state_d = violation ? RESP : REQ;
      REQ:     if (mem_gnt)                    state_d = we_q ? RESP : WAIT_R;
      WAIT_R:  if (mem_rvalid || timed_out)    state_d = RESP;
      RESP:    if (resp_ready)                 state_d = IDLE;
      default:                                 state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from the registered state
  always_comb begin
    in_ready   = (state_q == IDLE);
    mem_req    = (state_q == REQ);
    resp_valid = (state_q == RESP);
  end

  // Request capture, read timer and response payload
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ro_q         <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      timer_q      <= '0;
      resp_data_q  <= '0;
      resp_fault_q <= 1'b0;
      resp_err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            ro_q    <= in_ro;
            we_q    <= in_we;
            wdata_q <= in_wdata;
            if (violation) begin
              resp_data_q  <= '0;
              resp_fault_q <= 1'b1;
              resp_err_q   <= 1'b0;
            end
          end
        end
        REQ: begin
          if (mem_gnt) begin
            timer_q      <= '0;
            resp_data_q  <= '0;
            resp_fault_q <= 1'b0;
            resp_err_q   <= 1'b0;
          end
        end
        WAIT_R: begin
          timer_q <= timer_q + TW'(1);
          if (mem_rvalid) begin
            resp_data_q <= mem_rdata;
            resp_err_q  <= 1'b0;
          end else if (timed_out) begin
            resp_data_q <= '0;
            resp_err_q  <= 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_fault_q <= 1'b0;
            resp_err_q   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Violation log. A violation accepted together with fault_clr restarts the count at 1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sticky_q <= 1'b0;
      cnt_q    <= '0;
      faddr_q  <= '0;
    end else if (accept && violation) begin
      sticky_q <= 1'b1;
      faddr_q  <= in_ri;
      if (fault_clr)       cnt_q <= CW'(1);
      else if (cnt_q != '1) cnt_q <= cnt_q + CW'(1);
    end else if (fault_clr) begin
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end
  end

  assign mem_addr     = ro_q;
  assign mem_we       = we_q;
  assign mem_wdata    = wdata_q;
  assign resp_data    = resp_data_q;
  assign resp_fault   = resp_fault_q;
  assign resp_err     = resp_err_q;
  assign fault_sticky = sticky_q;
  assign fault_cnt    = cnt_q;
  assign fault_addr   = faddr_q;

endmodule

// File: tb/tb_sfi_mem_req.sv
// Scoreboard bench for sfi_mem_req (CW=2, TIMEOUT=4).
// Stimulus pushes each expected response into a queue.
// A separate monitor pops the queue and compares at every response handshake.
module tb_sfi_mem_req;

  localparam int unsigned AW = 64;
  localparam int unsigned DW = 64;
  localparam int unsigned CW = 2;
  localparam int unsigned TO = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, in_we;
  logic [AW-1:0] in_ri, in_ro;
  logic [DW-1:0] in_wdata;
  logic          mem_req, mem_gnt, mem_we, mem_rvalid;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          resp_valid, resp_ready, resp_fault, resp_err;
  logic [DW-1:0] resp_data;
  logic          fault_sticky, fault_clr;
  logic [CW-1:0] fault_cnt;
  logic [AW-1:0] fault_addr;

  sfi_mem_req #(.AW(AW), .DW(DW), .CW(CW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_ri(in_ri), .in_ro(in_ro),
    .in_we(in_we), .in_wdata(in_wdata),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_fault(resp_fault), .resp_err(resp_err),
    .fault_sticky(fault_sticky), .fault_cnt(fault_cnt), .fault_addr(fault_addr),
    .fault_clr(fault_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic          fault;
    logic          err;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] d, input logic f, input logic e);
    exp_t x;
    x.data = d; x.fault = f; x.err = e;
    sb.push_back(x);
  endtask

  // Monitor: samples on the falling edge; a response is consumed on the next rising edge
  always @(negedge clk) begin
    if (rst_n === 1'b1 && resp_valid === 1'b1 && resp_ready === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_resp: got data=%h fault=%b err=%b, expected none",
                 resp_data, resp_fault, resp_err);
      end else begin
        exp_t x;
        x = sb.pop_front();
        check("resp_data",  resp_data,  x.data);
        check("resp_fault", 64'(resp_fault), 64'(x.fault));
        check("resp_err",   64'(resp_err),   64'(x.err));
      end
    end
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  task automatic issue(input logic [AW-1:0] ri, input logic [AW-1:0] ro,
                       input logic we, input logic [DW-1:0] wd, input logic clr);
    in_valid = 1'b1; in_ri = ri; in_ro = ro; in_we = we; in_wdata = wd; fault_clr = clr;
    tick();
    in_valid = 1'b0; fault_clr = 1'b0;
  endtask

  task automatic violation(input logic [AW-1:0] ri, input logic clr, input int exp_cnt);
    push('0, 1'b1, 1'b0);
    issue(ri, '0, 1'b0, '0, clr);
    check("viol_resp_valid", 64'(resp_valid), 64'd1);
    check("viol_mem_req",    64'(mem_req),    64'd0);
    check("viol_cnt",        64'(fault_cnt),  64'(exp_cnt));
    check("viol_sticky",     64'(fault_sticky), 64'd1);
    check("viol_addr",       fault_addr,      ri);
    tick();
    check("viol_back_idle",  64'(in_ready),   64'd1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_ri = '0; in_ro = '0; in_we = 1'b0; in_wdata = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; resp_ready = 1'b1; fault_clr = 1'b0;
    tick(); tick();
    // Reset state
    check("rst_in_ready",   64'(in_ready),     64'd1);
    check("rst_mem_req",    64'(mem_req),      64'd0);
    check("rst_resp_valid", 64'(resp_valid),   64'd0);
    check("rst_sticky",     64'(fault_sticky), 64'd0);
    check("rst_cnt",        64'(fault_cnt),    64'd0);
    check("rst_faddr",      fault_addr,        64'd0);
    check("rst_rdata",      resp_data,         64'd0);
    check("rst_mem_addr",   mem_addr,          64'd0);
    rst_n = 1'b1;
    tick();

    // Legal read: grant one cycle late, rvalid on the third WAIT_R cycle
    push(64'hDEADBEEF, 1'b0, 1'b0);
    issue(64'hA2199872, 64'hA2199872, 1'b0, '0, 1'b0);
    check("rd_mem_req",  64'(mem_req),  64'd1);
    check("rd_mem_addr", mem_addr,      64'hA2199872);
    check("rd_mem_we",   64'(mem_we),   64'd0);
    check("rd_in_ready", 64'(in_ready), 64'd0);
    tick();
    check("rd_req_hold", 64'(mem_req),  64'd1);
    mem_gnt = 1'b1; tick(); mem_gnt = 1'b0;
    check("rd_req_drop", 64'(mem_req),  64'd0);
    tick(); tick();
    mem_rvalid = 1'b1; mem_rdata = 64'hDEADBEEF; tick(); mem_rvalid = 1'b0;
    check("rd_resp_valid", 64'(resp_valid), 64'd1);
    tick();
    check("rd_idle", 64'(in_ready), 64'd1);

    // Violation: immediate fault, no memory request
    violation(64'h00FFEEDD, 1'b0, 1);

    // Read timeout after exactly TIMEOUT waiting cycles
    push('0, 1'b0, 1'b1);
    issue(64'h100, 64'h100, 1'b0, '0, 1'b0);
    mem_gnt = 1'b1; tick(); mem_gnt = 1'b0;
    tick(); tick(); tick();
    check("to_not_yet", 64'(resp_valid), 64'd0);
    tick();
    check("to_resp_valid", 64'(resp_valid), 64'd1);
    tick();
    // Late rvalid in IDLE must be ignored
    mem_rvalid = 1'b1; mem_rdata = 64'h55; tick(); mem_rvalid = 1'b0;
    check("late_rv_no_resp", 64'(resp_valid), 64'd0);
    check("late_rv_ready",   64'(in_ready),   64'd1);

    // rvalid on the timeout cycle: data wins
    push(64'hCAFE, 1'b0, 1'b0);
    issue(64'h200, 64'h200, 1'b0, '0, 1'b0);
    mem_gnt = 1'b1; tick(); mem_gnt = 1'b0;
    tick(); tick(); tick();
    mem_rvalid = 1'b1; mem_rdata = 64'hCAFE; tick(); mem_rvalid = 1'b0;
    check("tie_resp_valid", 64'(resp_valid), 64'd1);
    tick();

    // Backpressure on a write with immediate grant
    push('0, 1'b0, 1'b0);
    resp_ready = 1'b0;
    issue(64'hA2199872, 64'hA2199872, 1'b1, 64'h1234, 1'b0);
    check("wr_mem_we",    64'(mem_we), 64'd1);
    check("wr_mem_wdata", mem_wdata,   64'h1234);
    mem_gnt = 1'b1; tick(); mem_gnt = 1'b0;
    check("wr_resp_n2", 64'(resp_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid",    64'(resp_valid), 64'd1);
      check("bp_data",     resp_data,       64'd0);
      check("bp_fault",    64'(resp_fault), 64'd0);
      check("bp_err",      64'(resp_err),   64'd0);
      check("bp_in_ready", 64'(in_ready),   64'd0);
    end
    resp_ready = 1'b1;
    tick();
    check("bp_idle",      64'(in_ready),   64'd1);
    check("bp_valid_low", 64'(resp_valid), 64'd0);

    // Counter saturation (CW=2), then clear together with a violation
    fault_clr = 1'b1; tick(); fault_clr = 1'b0;
    check("clr_cnt",    64'(fault_cnt),    64'd0);
    check("clr_sticky", 64'(fault_sticky), 64'd0);
    violation(64'h11, 1'b0, 1);
    violation(64'h22, 1'b0, 2);
    violation(64'h33, 1'b0, 3);
    violation(64'h44, 1'b0, 3);
    violation(64'h55, 1'b1, 1);

    // Reset during REQ abandons the request without a response
    issue(64'h300, 64'h300, 1'b0, '0, 1'b0);
    check("mid_req", 64'(mem_req), 64'd1);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    check("mid_mem_req",  64'(mem_req),      64'd0);
    check("mid_in_ready", 64'(in_ready),     64'd1);
    check("mid_sticky",   64'(fault_sticky), 64'd0);
    check("mid_cnt",      64'(fault_cnt),    64'd0);
    check("mid_faddr",    fault_addr,        64'd0);
    check("mid_rvalid",   64'(resp_valid),   64'd0);

    // Recovery: write with immediate grant responds at N+2
    push('0, 1'b0, 1'b0);
    issue(64'h400, 64'h400, 1'b1, 64'h9, 1'b0);
    mem_gnt = 1'b1; tick(); mem_gnt = 1'b0;
    check("rec_resp_valid", 64'(resp_valid), 64'd1);
    tick(); tick();

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
